// File: rtl/interlacer.sv
// -----------------------------------------------------------------------------
// interlacer
//   Converts a progressive Avalon-ST video stream (control packet + WIDTH x
//   HEIGHT video packet) into an interlaced field stream. Each input frame
//   yields one 10-beat control packet describing a WIDTH x HEIGHT/2 field,
//   then a video packet carrying only the even lines (F0) or only the odd
//   lines (F1). Field parity alternates frame by frame.
//
// Optional feature macro: INTERLACER_FIXED_F0_EN
//   When defined, the field parity is pinned to F0 for every frame.
//
// Ports
//   clock, reset              rising-edge clock, synchronous active-high reset
//   din_*                     Avalon-ST sink (data/valid/ready/sop/eop)
//   dout_*                    Avalon-ST source, single registered stage
//   field_out                 parity of the field being / about to be emitted
// -----------------------------------------------------------------------------
module interlacer #(
    parameter int BITS_PER_SYMBOL = 8,
    parameter int WIDTH           = 640,
    parameter int HEIGHT          = 480
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [BITS_PER_SYMBOL-1:0] din_data,
    input  logic                       din_valid,
    output logic                       din_ready,
    input  logic                       din_startofpacket,
    input  logic                       din_endofpacket,
    output logic [BITS_PER_SYMBOL-1:0] dout_data,
    output logic                       dout_valid,
    input  logic                       dout_ready,
    output logic                       dout_startofpacket,
    output logic                       dout_endofpacket,
    output logic                       field_out
);

    localparam int DATA_WIDTH = BITS_PER_SYMBOL;

    localparam logic [15:0] WIDTH_W      = 16'(WIDTH);
    localparam logic [15:0] HALF_H       = 16'(HEIGHT / 2);
    localparam logic [11:0] COL_LAST     = 12'(WIDTH - 1);
    localparam logic [11:0] LINE_LAST    = 12'(HEIGHT - 1);
    localparam logic [11:0] LINE_LAST_F0 = 12'(HEIGHT - 2);

    typedef enum logic [2:0] {
        IDLE,
        CTRL_IN,
        CTRL_OUT,
        WAIT_VID,
        LINES,
        FLUSH_EOP
    } state_t;

    state_t                  state_q, state_d;
    logic                    field_q, field_d;
    logic [11:0]             line_q, line_d;
    logic [11:0]             col_q, col_d;
    logic [3:0]              beat_q, beat_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   out_data_q, out_data_d;
    logic                    out_sop_q, out_sop_d;
    logic                    out_eop_q, out_eop_d;

    logic                    ready_c;
    logic                    can_load;
    logic                    kept;
    logic                    last_kept_pos;
    logic                    final_done;
    logic                    field_flip;
    logic [3:0]              din_nib;
    logic [3:0]              ctrl_nib;

    // Parity the next frame will use once the current one finishes.
`ifdef INTERLACER_FIXED_F0_EN
    assign field_flip = 1'b0;
`else
    assign field_flip = ~field_q;
`endif

    assign din_nib       = din_data[3:0];
    assign can_load      = !out_valid_q || dout_ready;
    assign kept          = (line_q[0] == field_q);
    assign last_kept_pos = (col_q == COL_LAST) &&
                           (line_q == (field_q ? LINE_LAST : LINE_LAST_F0));
    // Only F0 has a dropped line after its last kept pixel.
    assign final_done    = !field_q && (line_q == LINE_LAST);

    // Outgoing control packet: type, width nibbles, field height nibbles,
    // interlace nibble.
    always_comb begin
        ctrl_nib = 4'h0;
        case (beat_q)
            4'd0:    ctrl_nib = 4'hF;
            4'd1:    ctrl_nib = WIDTH_W[15:12];
            4'd2:    ctrl_nib = WIDTH_W[11:8];
            4'd3:    ctrl_nib = WIDTH_W[7:4];
            4'd4:    ctrl_nib = WIDTH_W[3:0];
            4'd5:    ctrl_nib = HALF_H[15:12];
            4'd6:    ctrl_nib = HALF_H[11:8];
            4'd7:    ctrl_nib = HALF_H[7:4];
            4'd8:    ctrl_nib = HALF_H[3:0];
            4'd9:    ctrl_nib = field_q ? 4'b1100 : 4'b1000;
            default: ctrl_nib = 4'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        line_d      = line_q;
        col_d       = col_q;
        beat_d      = beat_q;
        // A pending beat clears on transfer and otherwise holds.
        out_valid_d = out_valid_q && !dout_ready;
        out_data_d  = out_data_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        ready_c     = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = 1'b1;
                beat_d  = 4'd0;
                if (din_valid && din_startofpacket && din_nib == 4'hF) begin
                    state_d = din_endofpacket ? CTRL_OUT : CTRL_IN;
                end
            end

            CTRL_IN: begin
                ready_c = 1'b1;
                beat_d  = 4'd0;
                if (din_valid && din_endofpacket) begin
                    state_d = CTRL_OUT;
                end
            end

            CTRL_OUT: begin
                // beat_q == 10 means all beats are loaded; leave once the
                // final one transfers.
                if (beat_q == 4'd10) begin
                    if (dout_ready) begin
                        state_d = WAIT_VID;
                    end
                end else if (can_load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = DATA_WIDTH'(ctrl_nib);
                    out_sop_d   = (beat_q == 4'd0);
                    out_eop_d   = (beat_q == 4'd9);
                    beat_d      = beat_q + 4'd1;
                end
            end

            WAIT_VID: begin
                ready_c = can_load;
                beat_d  = 4'd0;
                if (din_valid && can_load && din_startofpacket) begin
                    if (din_nib == 4'h0) begin
                        out_valid_d = 1'b1;
                        out_data_d  = din_data;
                        out_sop_d   = 1'b1;
                        out_eop_d   = din_endofpacket;
                        line_d      = 12'd0;
                        col_d       = 12'd0;
                        if (din_endofpacket) begin
                            // Empty video packet: the header closes the field.
                            field_d = field_flip;
                            state_d = IDLE;
                        end else begin
                            state_d = LINES;
                        end
                    end else if (din_nib == 4'hF) begin
                        state_d = din_endofpacket ? CTRL_OUT : CTRL_IN;
                    end
                end
            end

            LINES: begin
                // Dropped lines never wait on the output stage.
                ready_c = kept ? can_load : 1'b1;
                if (din_valid && ready_c) begin
                    if (kept) begin
                        out_valid_d = 1'b1;
                        out_data_d  = din_data;
                        out_sop_d   = 1'b0;
                        out_eop_d   = last_kept_pos || din_endofpacket;
                    end
                    if (col_q == COL_LAST) begin
                        col_d  = 12'd0;
                        line_d = line_q + 12'd1;
                    end else begin
                        col_d = col_q + 12'd1;
                    end
                    if (line_q == LINE_LAST && col_q == COL_LAST) begin
                        field_d = field_flip;
                        state_d = IDLE;
                    end else if (din_endofpacket) begin
                        if (kept || final_done) begin
                            field_d = field_flip;
                            state_d = IDLE;
                        end else begin
                            state_d = FLUSH_EOP;
                        end
                    end
                end
            end

            FLUSH_EOP: begin
                // Close the truncated field with a filler beat.
                if (can_load) begin
                    out_valid_d = 1'b1;
                    out_data_d  = '0;
                    out_sop_d   = 1'b0;
                    out_eop_d   = 1'b1;
                    field_d     = field_flip;
                    state_d     = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            field_q     <= 1'b0;
            line_q      <= 12'd0;
            col_q       <= 12'd0;
            beat_q      <= 4'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            line_q      <= line_d;
            col_q       <= col_d;
            beat_q      <= beat_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
        end
    end

    assign din_ready          = ready_c && !reset;
    assign dout_valid         = out_valid_q;
    assign dout_data          = out_data_q;
    assign dout_startofpacket = out_sop_q;
    assign dout_endofpacket   = out_eop_q;
    assign field_out          = field_q;

endmodule

// File: tb/tb_interlacer.sv
// -----------------------------------------------------------------------------
// tb_interlacer
//   Self-checking bench for interlacer with WIDTH=4, HEIGHT=4. Frames are
//   described at frame level (pixel array + end-of-packet position) and the
//   expected field stream is derived from the line-parity rules.
// -----------------------------------------------------------------------------
module tb_interlacer;

    localparam int W = 4;
    localparam int H = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din_data = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready;
    logic       din_sop = 1'b0;
    logic       din_eop = 1'b0;
    logic [7:0] dout_data;
    logic       dout_valid;
    logic       dout_ready = 1'b1;
    logic       dout_sop;
    logic       dout_eop;
    logic       field_out;

    always #5 clk = ~clk;

    interlacer #(
        .BITS_PER_SYMBOL(8),
        .WIDTH          (W),
        .HEIGHT         (H)
    ) dut (
        .clock             (clk),
        .reset             (rst),
        .din_data          (din_data),
        .din_valid         (din_valid),
        .din_ready         (din_ready),
        .din_startofpacket (din_sop),
        .din_endofpacket   (din_eop),
        .dout_data         (dout_data),
        .dout_valid        (dout_valid),
        .dout_ready        (dout_ready),
        .dout_startofpacket(dout_sop),
        .dout_endofpacket  (dout_eop),
        .field_out         (field_out)
    );

    int         checks = 0;
    int         errors = 0;
    logic [9:0] exp_q[$];      // {sop, eop, data}
    logic [9:0] got_q[$];
    bit         model_field = 1'b0;
    int         ready_mode = 0; // 0 always ready, 1 toggle, 2 random
    bit         mon_en = 1'b0;
    int         stall_viol = 0;
    int         drop_viol = 0;
    int         timeouts = 0;
    bit         prev_stall = 1'b0;
    logic [9:0] prev_beat = '0;
    logic [9:0] mon_beat;
    logic [7:0] pix[H][W];

    // Output side: drive ready on the falling edge, sample just before rise.
    always @(negedge clk) begin
        case (ready_mode)
            0:       dout_ready = 1'b1;
            1:       dout_ready = ~dout_ready;
            default: dout_ready = 1'($urandom_range(0, 1));
        endcase
        #4;
        if (mon_en) begin
            mon_beat = {dout_sop, dout_eop, dout_data};
            if (prev_stall && (!dout_valid || mon_beat !== prev_beat)) stall_viol++;
            if (dout_valid && dout_ready) got_q.push_back(mon_beat);
            prev_stall = dout_valid && !dout_ready;
            prev_beat  = mon_beat;
        end else begin
            prev_stall = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

    task automatic send_beat(input logic [7:0] d, input bit s, input bit e,
                             input bit dropped, input int gap_max);
        int n;
        @(negedge clk);
        if (gap_max > 0) begin
            din_valid = 1'b0;
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        din_data  = d;
        din_sop   = s;
        din_eop   = e;
        din_valid = 1'b1;
        n = 0;
        forever begin
            #4;
            if (dropped && !din_ready) drop_viol++;
            if (din_ready) break;
            n++;
            if (n > 200) begin
                timeouts++;
                break;
            end
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    // Frame-level reference: control packet, header, then pixels of lines with
    // line%2 == field, up to the input end-of-packet position.
    task automatic model_frame(input bit has_ctrl, input int eop_l, input int eop_c);
        int f;
        int last_kept_l;
        if (!has_ctrl) return;
        f = int'(model_field);
        exp_q.push_back({2'b10, 8'h0F});
        for (int s = 12; s >= 0; s -= 4) exp_q.push_back({2'b00, 8'((W >> s) & 15)});
        for (int s = 12; s >= 0; s -= 4) exp_q.push_back({2'b00, 8'(((H / 2) >> s) & 15)});
        exp_q.push_back({2'b01, (f == 1) ? 8'h0C : 8'h08});
        exp_q.push_back({2'b10, 8'h00});
        last_kept_l = H - 2 + f;
        for (int l = 0; l < H; l++) begin
            for (int c = 0; c < W; c++) begin
                if (l * W + c <= eop_l * W + eop_c && (l % 2) == f) begin
                    exp_q.push_back({1'b0,
                                     (l == last_kept_l && c == W - 1) || (l == eop_l && c == eop_c),
                                     pix[l][c]});
                end
            end
        end
        if ((eop_l % 2) != f && eop_l < last_kept_l) exp_q.push_back({2'b01, 8'h00});
`ifndef INTERLACER_FIXED_F0_EN
        model_field = ~model_field;
`endif
    endtask

    task automatic wait_drain();
        int n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) timeouts++;
        repeat (6) @(negedge clk);
    endtask

    task automatic run_frame(input bit has_ctrl, input int eop_l, input int eop_c,
                             input bit rand_pix, input int gap);
        int f;
        f = int'(model_field);
        for (int l = 0; l < H; l++)
            for (int c = 0; c < W; c++)
                pix[l][c] = rand_pix ? 8'($urandom_range(0, 255)) : 8'(16 * l + c);
        model_frame(has_ctrl, eop_l, eop_c);
        if (has_ctrl) begin
            send_beat(8'h0F, 1'b1, 1'b0, 1'b0, gap);
            for (int i = 1; i <= 8; i++) send_beat(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0, gap);
            send_beat(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, gap);
        end
        send_beat(8'h00, 1'b1, 1'b0, 1'b0, gap);
        for (int l = 0; l < H; l++)
            for (int c = 0; c < W; c++)
                if (l * W + c <= eop_l * W + eop_c)
                    send_beat(pix[l][c], 1'b0, (l == eop_l && c == eop_c),
                              has_ctrl && ((l % 2) != f), gap);
        @(negedge clk);
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
        wait_drain();
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL reset_din_ready got %0b exp 0", din_ready); end
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid got %0b exp 0", dout_valid); end
        checks++; if (dout_data !== 8'h00) begin errors++; $display("FAIL reset_dout_data got %02h exp 00", dout_data); end
        checks++; if ({dout_sop, dout_eop} !== 2'b00) begin errors++; $display("FAIL reset_delims got %02b exp 00", {dout_sop, dout_eop}); end
        checks++; if (field_out !== 1'b0) begin errors++; $display("FAIL reset_field got %0b exp 0", field_out); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL post_reset_din_ready got %0b exp 1", din_ready); end
        mon_en = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_two_frames();
        exp_q.delete(); got_q.delete();
        ready_mode = 0;
        run_frame(1'b1, H - 1, W - 1, 1'b0, 0);
        run_frame(1'b1, H - 1, W - 1, 1'b0, 0);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL two_frames_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL two_frames_beat%0d got %03h exp %03h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (field_out !== model_field) begin errors++; $display("FAIL two_frames_field got %0b exp %0b", field_out, model_field); end
        $display("test_two_frames beats=%0d", got_q.size());
    endtask

    task automatic test_stall();
        exp_q.delete(); got_q.delete();
        stall_viol = 0; drop_viol = 0;
        ready_mode = 1;
        run_frame(1'b1, H - 1, W - 1, 1'b0, 0);
        ready_mode = 0;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_beat%0d got %03h exp %03h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL stall_hold got %0d unstable exp 0", stall_viol); end
        checks++; if (drop_viol !== 0) begin errors++; $display("FAIL stall_drop_ready got %0d blocked exp 0", drop_viol); end
        checks++; if (field_out !== model_field) begin errors++; $display("FAIL stall_field got %0b exp %0b", field_out, model_field); end
        $display("test_stall beats=%0d", got_q.size());
    endtask

    task automatic test_no_ctrl();
        exp_q.delete(); got_q.delete();
        run_frame(1'b0, H - 1, W - 1, 1'b0, 0);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL no_ctrl_count got %0d exp 0", got_q.size()); end
        checks++; if (field_out !== model_field) begin errors++; $display("FAIL no_ctrl_field got %0b exp %0b", field_out, model_field); end
        $display("test_no_ctrl beats=%0d", got_q.size());
    endtask

    task automatic test_early_eop();
        exp_q.delete(); got_q.delete();
        if (model_field) run_frame(1'b1, H - 1, W - 1, 1'b0, 0);
        exp_q.delete(); got_q.delete();
        run_frame(1'b1, 1, 2, 1'b0, 0);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL early_eop_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL early_eop_beat%0d got %03h exp %03h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (field_out !== model_field) begin errors++; $display("FAIL early_eop_field got %0b exp %0b", field_out, model_field); end
        $display("test_early_eop beats=%0d", got_q.size());
    endtask

    task automatic test_random();
        int el, ec;
        exp_q.delete(); got_q.delete();
        stall_viol = 0; drop_viol = 0;
        ready_mode = 2;
        for (int fr = 0; fr < 10; fr++) begin
            if ($urandom_range(0, 1) == 0) begin
                el = H - 1; ec = W - 1;
            end else begin
                el = $urandom_range(0, H - 1); ec = $urandom_range(0, W - 1);
            end
            run_frame(($urandom_range(0, 5) != 0), el, ec, 1'b1, 2);
            $display("test_random frame %0d eop=(%0d,%0d) exp=%0d got=%0d", fr, el, ec, exp_q.size(), got_q.size());
        end
        ready_mode = 0;
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL random_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_beat%0d got %03h exp %03h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL random_hold got %0d unstable exp 0", stall_viol); end
        checks++; if (drop_viol !== 0) begin errors++; $display("FAIL random_drop_ready got %0d blocked exp 0", drop_viol); end
        checks++; if (field_out !== model_field) begin errors++; $display("FAIL random_field got %0b exp %0b", field_out, model_field); end
    endtask

    task automatic test_reset_mid();
        exp_q.delete(); got_q.delete();
        // Make the pre-reset parity F1 where the mode allows it.
        if (!model_field) run_frame(1'b1, H - 1, W - 1, 1'b0, 0);
        send_beat(8'h0F, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 8; i++) send_beat(8'h00, 1'b0, 1'b0, 1'b0, 0);
        send_beat(8'h00, 1'b0, 1'b1, 1'b0, 0);
        send_beat(8'h00, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 0; i < 5; i++) send_beat(8'(i), 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        din_valid = 1'b0;
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_valid got %0b exp 0", dout_valid); end
        checks++; if (field_out !== 1'b0) begin errors++; $display("FAIL reset_mid_field got %0b exp 0", field_out); end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_idle_ready got %0b exp 1", din_ready); end
        model_field = 1'b0;
        exp_q.delete(); got_q.delete();
        mon_en = 1'b1;
        run_frame(1'b1, H - 1, W - 1, 1'b1, 0);
        checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL reset_mid_count got %0d exp %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL reset_mid_beat%0d got %03h exp %03h", i, got_q[i], exp_q[i]); end
        end
        $display("test_reset_mid beats=%0d", got_q.size());
    endtask

    initial begin
        test_reset();
        test_two_frames();
        test_stall();
        test_no_ctrl();
        test_early_eop();
        test_random();
        test_reset_mid();
        checks++; if (timeouts !== 0) begin errors++; $display("FAIL timeouts got %0d exp 0", timeouts); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
